spi_peripheral: RTL
===================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have port clk, input, 1, system clock (10 MHz nominal); the only clock.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port sclk, input, 1, SPI clock, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-004 SHALL have port copi, input, 1, SPI controller-out data, MSB first.
REQ-005 SHALL have port ncs, input, 1, SPI chip select, active low.
REQ-006 SHALL have port en_reg_out_7_0, output, 8, register 0x00.
REQ-007 SHALL have port en_reg_out_15_8, output, 8, register 0x01.
REQ-008 SHALL have port en_reg_pwm_7_0, output, 8, register 0x02.
REQ-009 SHALL have port en_reg_pwm_15_8, output, 8, register 0x03.
REQ-010 SHALL have port pwm_duty_cycle, output, 8, register 0x04.
REQ-011 SHALL have port wr_pulse, output, 1, one-clk strobe on each committed register write.

Function
REQ-012 SHALL pass sclk, copi and ncs each through a 2-flop synchronizer into clk; all decoding SHALL use the synchronized copies only.
REQ-013 SHALL detect the sclk rising edge as sync_sclk=1 with its previous sample 0; ncs falling and rising edges SHALL be detected the same way.
REQ-014 SHALL define a transaction as the interval from ncs falling to ncs rising.
REQ-015 SHALL, on each sclk rising edge while synchronized ncs=0, shift copi into a 16-bit shift register LSB-side and increment a 5-bit bit counter that saturates at 17.
REQ-016 SHALL clear the shift register and bit counter on the ncs falling edge.
REQ-017 SHALL interpret the frame as bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
REQ-018 SHALL commit on the ncs rising edge only if bit count == 16, bit15 == 1 and address <= 0x04.
REQ-019 SHALL discard the frame with no register change and no wr_pulse in every other case: count <16, count >16, read, or address 0x05-0x7F.
REQ-020 SHALL update the target register on the clk edge following the detected ncs rising edge and assert wr_pulse for exactly that one cycle.
REQ-021 SHALL have a total latency of at most 4 clk cycles from raw ncs rising to the register value appearing on outputs (2 sync + 1 edge detect + 1 commit).
REQ-022 SHALL implement the control FSM with states IDLE (ncs high), RECV (shifting), COMMIT (one cycle, decode and write), then return to IDLE.
REQ-023 SHALL re-enter RECV with a cleared counter when an ncs falling edge occurs in COMMIT; the pending commit SHALL still complete.
REQ-024 SHALL ignore sclk edges while ncs is high.
REQ-025 SHALL hold all registers unchanged between commits; outputs SHALL be direct register values with no combinational path from SPI pins.

Reset
REQ-026 SHALL asynchronously drive all five registers to 0x00, wr_pulse to 0, the FSM to IDLE, the counter to 0, the shift register to 0 and the synchronizer flops to sclk=0, copi=0, ncs=1 while rst=1.
REQ-027 SHALL abort a transaction in progress when rst is asserted mid-frame; the frame SHALL not be committed and the first frame after reset release SHALL decode normally.

Structure
REQ-028 SHALL place register addresses (0x00-0x04), MAX_ADDR, FRAME_BITS=16, the counter width and the FSM state enum in a shared package spi_pkg.
REQ-029 SHALL instantiate sub-module sync2 (2-flop synchronizer, 1-bit, reset value as parameter) three times.

Verification
REQ-030 SHALL cover: reset, then write frame 0x80F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 within 4 clk of ncs high, one wr_pulse, all other registers 0x00.
REQ-031 SHALL cover: write frame 0x8480 -> pwm_duty_cycle = 0x80; then write 0x84FF -> 0xFF.
REQ-032 SHALL cover: write frames to addr 0x05 (0x8555) and a read frame (0x0055) -> no register change, no wr_pulse.
REQ-033 SHALL cover: 15-bit and 17-bit frames carrying data 0xAA to addr 0x02 -> en_reg_pwm_7_0 stays unchanged.
REQ-034 SHALL cover: rst asserted after 8 bits of frame 0x81FF -> all registers 0x00; a following full frame 0x81FF -> en_reg_out_15_8 = 0xFF.
REQ-035 SHALL cover: two back-to-back frames (0x8201, 0x8302) with 2 clk of ncs high between them -> en_reg_pwm_7_0 = 0x01, en_reg_pwm_15_8 = 0x02, two wr_pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI register peripheral.
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;
  localparam logic [6:0] MAX_ADDR       = ADDR_PWM_DUTY;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_COMMIT
  } state_t;

  // A frame is written only if exactly FRAME_BITS bits arrived, it is a write and it targets a mapped address.
  function automatic logic frame_commit_ok(input logic [CNT_W-1:0] cnt,
                                           input logic [FRAME_BITS-1:0] frame);
    return (cnt == CNT_FULL) && frame[15] && (frame[14:8] <= MAX_ADDR);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI (mode 0) register peripheral: 16-bit frames {W, addr[6:0], data[7:0]}
// committed into five 8-bit registers on chip-select release.
module spi_peripheral
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse
);

  logic sclk_s;
  logic copi_s;
  logic ncs_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclk_s));
  sync2 #(.RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst(rst), .d_i(copi), .q_o(copi_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst(rst), .d_i(ncs),  .q_o(ncs_s));

  logic sclk_prev_q;
  logic ncs_prev_q;
  logic sclk_rise;
  logic ncs_fall;
  logic ncs_rise;

  // Previous samples of the synchronized lines for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  state_t                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [7:0]            out_lo_q;
  logic [7:0]            out_hi_q;
  logic [7:0]            pwm_lo_q;
  logic [7:0]            pwm_hi_q;
  logic [7:0]            duty_q;
  logic                  wr_pulse_q;
  logic                  commit_ok;
  logic [6:0]            addr;

  // Frame decode of the current shift contents, consumed in COMMIT.
  always_comb begin
    commit_ok = frame_commit_ok(cnt_q, shift_q);
    addr      = shift_q[14:8];
  end

  // Control FSM with frame capture and register file; all outputs registered.
  // Capture runs independently of state so a new frame starting during COMMIT is not lost;
  // COMMIT reads the pre-clear shift contents because the clear is non-blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      out_lo_q   <= '0;
      out_hi_q   <= '0;
      pwm_lo_q   <= '0;
      pwm_hi_q   <= '0;
      duty_q     <= '0;
      wr_pulse_q <= 1'b0;
    end else begin
      wr_pulse_q <= 1'b0;

      if (ncs_fall) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (sclk_rise && !ncs_s) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
        if (cnt_q != CNT_SAT) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_q <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (ncs_rise) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (commit_ok) begin
            wr_pulse_q <= 1'b1;
            case (addr)
              ADDR_EN_OUT_LO: out_lo_q <= shift_q[7:0];
              ADDR_EN_OUT_HI: out_hi_q <= shift_q[7:0];
              ADDR_EN_PWM_LO: pwm_lo_q <= shift_q[7:0];
              ADDR_EN_PWM_HI: pwm_hi_q <= shift_q[7:0];
              ADDR_PWM_DUTY:  duty_q   <= shift_q[7:0];
              default: ;
            endcase
          end
          state_q <= ncs_fall ? ST_RECV : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_pulse        = wr_pulse_q;

endmodule
